mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DEPTH  64  number of data-RAM words; valid word addresses 0..DEPTH-1
  AW  6  RAM index bits, equal to log2(DEPTH)
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on its rising edge
  reset  in  1  synchronous, active-high reset
  cpu_req  in  1  pipeline MEM-stage request; held until cpu_ack
  cpu_we  in  1  1=write, 0=read
  cpu_addr  in  32  word address
  cpu_wdata  in  32  write data
  cpu_ack  out  1  one-cycle completion pulse
  cpu_err  out  1  out-of-range flag; valid with cpu_ack
  cpu_rdata  out  32  read data; valid with cpu_ack
  cpu_stall  out  1  cpu_req & ~cpu_ack
  dma_req, dma_we, dma_addr, dma_wdata  in  1/1/32/32  loader/debug port; same meanings as the cpu_* inputs
  dma_ack, dma_err, dma_rdata  out  1/1/32  same meanings as the cpu_* outputs
  ram_address  out  32  RAM address; zero-extended index
  ram_write_data  out  32  RAM write data
  ram_MemWrite  out  1  RAM write strobe
  ram_MemRead  out  1  RAM read enable
  ram_read_data  in  32  combinational RAM read data

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-004 In IDLE, when at least one request is eligible, the arbiter SHALL latch the winner id, we, addr and wdata, then go to ACCESS; with no eligible request it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: if only one request is eligible, that request wins; if both are eligible, the port that did not win last time wins.
REQ-006 In ACCESS with an in-range address (addr < DEPTH), the block SHALL drive ram_address = addr[AW-1:0] zero-extended and ram_write_data = wdata, and assert exactly one of ram_MemWrite (we=1) or ram_MemRead (we=0) for that one cycle.
REQ-007 In ACCESS with addr >= DEPTH, ram_MemWrite and ram_MemRead SHALL both stay 0, and the block SHALL set err=1 and rdata=0.
REQ-008 At the end of ACCESS, the block SHALL register ram_read_data into the winner's rdata (reads only; writes return rdata=0), set the winner's ack (plus err when applicable), and go to DONE.
REQ-009 In DONE, the winner's ack SHALL be high for exactly one cycle, and the just-acked port SHALL be ineligible in that cycle.
REQ-010 In DONE, if the other port is requesting, it SHALL win and the FSM SHALL go to ACCESS; otherwise the FSM SHALL return to IDLE.
REQ-011 Throughput SHALL be one access per 2 cycles under contention; uncontended latency SHALL be req seen in IDLE -> ack 2 cycles later.
REQ-012 Each port's rdata and err SHALL hold their values until that port's next ack.
REQ-013 Outside ACCESS, ram_MemWrite and ram_MemRead SHALL be 0, and ram_address and ram_write_data SHALL be 0.
REQ-014 cpu_ack and dma_ack SHALL never be high in the same cycle.
REQ-015 A requester that drops req before its ack SHALL forfeit the request, unless that request was already latched.

Reset
REQ-016 When reset is high at a clock edge, the block SHALL set state=IDLE, all ack/err=0, all rdata=0, and last-winner=dma, so that cpu wins the first tie.
REQ-017 ram_MemWrite SHALL be gated by ~reset, so that reset asserted during ACCESS causes no RAM write and no ack.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, DONE), the port-id constants (PORT_CPU=0, PORT_DMA=1), and the DEPTH default.
REQ-019 A sub-module rr_arb2 SHALL implement the 2-input round-robin pick (inputs: req[1:0], mask[1:0], last; outputs: grant id, valid).

Verification
REQ-020 The bench SHALL check: cpu read with addr=5 and RAM[5]=109 -> ram_MemRead high for 1 cycle, cpu_ack 2 cycles after req, cpu_rdata=109, cpu_err=0.
REQ-021 The bench SHALL check: dma write with addr=62 and wdata=0xDEAD, then cpu read of addr 62 -> exactly one ram_MemWrite cycle, followed by cpu_rdata=0xDEAD.
REQ-022 The bench SHALL check: cpu and dma requesting together continuously, 8 acks -> acks alternate cpu, dma, cpu, ...; cpu first; an ack every 2nd cycle.
REQ-023 The bench SHALL check: cpu write with addr=64 -> no ram_MemWrite, cpu_ack with cpu_err=1 and cpu_rdata=0; RAM contents unchanged.
REQ-024 The bench SHALL check: reset pulsed during the ACCESS cycle of a dma write to addr=3 -> RAM[3] unchanged, no dma_ack, state IDLE.
REQ-025 The bench SHALL check: cpu_req held, dma idle -> cpu_stall high until cpu_ack, then low; a second cpu request is not eligible in the DONE cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port ids and default RAM depth for the memory arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;
   localparam int DEF_DEPTH = 64;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the port that did not win last time is granted
module rr_arb2 (
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       last,
   output logic       grant,
   output logic       valid
);
   logic [1:0] w_elig;
   assign w_elig = req & ~mask;
   assign valid  = |w_elig;
   assign grant  = &w_elig ? ~last : w_elig[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read data RAM between a cpu and a dma port, one access per two cycles
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_ack,
   output logic        dma_err,
   output logic [31:0] dma_rdata,
   output logic [31:0] ram_address,
   output logic [31:0] ram_write_data,
   output logic        ram_MemWrite,
   output logic        ram_MemRead,
   input  logic [31:0] ram_read_data
);
   state_t      r_state, w_next;
   logic        r_id, r_we, r_last;
   logic [31:0] r_addr, r_wdata;
   logic        r_cpu_ack, r_cpu_err, r_dma_ack, r_dma_err;
   logic [31:0] r_cpu_rdata, r_dma_rdata;
   logic [1:0]  w_mask;
   logic        w_grant, w_valid, w_acc, w_in, w_latch, w_cpu_done, w_dma_done;
   logic [31:0] w_rdata;
   // the port acked in DONE may still hold req for a cycle; keep it out of that arbitration
   assign w_mask = (r_state == DONE) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
   rr_arb2 u_arb (
      .req   ({dma_req, cpu_req}),
      .mask  (w_mask),
      .last  (r_last),
      .grant (w_grant),
      .valid (w_valid)
   );
   always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
   always_comb begin
      w_acc          = r_state == ACCESS;
      w_in           = r_addr < 32'(DEPTH);
      w_latch        = !w_acc && w_valid;
      w_next         = w_acc ? DONE : (w_valid ? ACCESS : IDLE);
      w_rdata        = (w_in && !r_we) ? ram_read_data : '0;
      w_cpu_done     = w_acc && r_id == PORT_CPU;
      w_dma_done     = w_acc && r_id == PORT_DMA;
      ram_address    = (w_acc && w_in) ? 32'(r_addr[AW-1:0]) : '0;
      ram_write_data = w_acc ? r_wdata : '0;
      ram_MemWrite   = w_acc && w_in && r_we && !reset;
      ram_MemRead    = w_acc && w_in && !r_we;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_id        <= PORT_CPU;
         r_last      <= PORT_DMA;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_ack   <= 1'b0;
         r_cpu_err   <= 1'b0;
         r_cpu_rdata <= '0;
         r_dma_ack   <= 1'b0;
         r_dma_err   <= 1'b0;
         r_dma_rdata <= '0;
      end else begin
         if (w_latch) begin
            r_id    <= w_grant;
            r_last  <= w_grant;
            r_we    <= w_grant ? dma_we : cpu_we;
            r_addr  <= w_grant ? dma_addr : cpu_addr;
            r_wdata <= w_grant ? dma_wdata : cpu_wdata;
         end
         r_cpu_ack <= w_cpu_done;
         r_dma_ack <= w_dma_done;
         if (w_cpu_done) begin
            r_cpu_err   <= !w_in;
            r_cpu_rdata <= w_rdata;
         end
         if (w_dma_done) begin
            r_dma_err   <= !w_in;
            r_dma_rdata <= w_rdata;
         end
      end
   end
   assign cpu_ack   = r_cpu_ack;
   assign cpu_err   = r_cpu_err;
   assign cpu_rdata = r_cpu_rdata;
   assign cpu_stall = cpu_req && !r_cpu_ack;
   assign dma_ack   = r_dma_ack;
   assign dma_err   = r_dma_err;
   assign dma_rdata = r_dma_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural 64-word RAM
module tb_mem_arbiter;
   import mem_arb_pkg::*;
   logic        clk = 1'b0, reset = 1'b1, tb_init = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
   logic        cpu_ack, cpu_err, cpu_stall, dma_ack, dma_err;
   logic [31:0] cpu_rdata, dma_rdata;
   logic [31:0] ram_address, ram_write_data, ram_read_data;
   logic        ram_MemWrite, ram_MemRead;
   logic [31:0] mem [64];
   int          n_chk = 0, n_pass = 0;
   int          lat, nw, nr, nacks;
   always #5 clk = ~clk;
   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
      .ram_address(ram_address), .ram_write_data(ram_write_data),
      .ram_MemWrite(ram_MemWrite), .ram_MemRead(ram_MemRead), .ram_read_data(ram_read_data)
   );
   assign ram_read_data = mem[ram_address[5:0]];
   always @(posedge clk) begin
      if (tb_init)
         for (int i = 0; i < 64; i++) mem[i] <= 32'(104 + i);
      else if (ram_MemWrite)
         mem[ram_address[5:0]] <= ram_write_data;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask
   task automatic do_req(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d,
                         output int l, output int w, output int r);
      if (p) begin dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d; end
      else   begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      l = -1; w = 0; r = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         w += int'(ram_MemWrite);
         r += int'(ram_MemRead);
         if (p ? dma_ack : cpu_ack) begin l = c; break; end
      end
      cpu_req = 0; dma_req = 0;
      @(negedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (2) @(negedge clk);
      reset = 0; tb_init = 0;
      chk("rst_state", 32'(dut.r_state), 32'(IDLE));
      chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 0);
      chk("rst_rdata", cpu_rdata | dma_rdata, 0);
      chk("idle_strobes", {30'd0, ram_MemWrite, ram_MemRead}, 0);
      // cpu read of address 5, cycle by cycle
      cpu_req = 1; cpu_we = 0; cpu_addr = 5;
      #1 chk("t1_stall_req", 32'(cpu_stall), 1);
      @(negedge clk);
      chk("t1_read_strobe", {30'd0, ram_MemWrite, ram_MemRead}, 32'b01);
      chk("t1_addr", ram_address, 5);
      chk("t1_no_ack_yet", 32'(cpu_ack), 0);
      @(negedge clk);
      chk("t1_ack", 32'(cpu_ack), 1);
      chk("t1_rdata", cpu_rdata, 109);
      chk("t1_err", 32'(cpu_err), 0);
      chk("t1_read_off", 32'(ram_MemRead), 0);
      chk("t1_stall_low", 32'(cpu_stall), 0);
      cpu_req = 0;
      @(negedge clk);
      chk("t1_ack_pulse", 32'(cpu_ack), 0);
      chk("t1_rdata_hold", cpu_rdata, 109);
      // dma write then cpu readback
      do_req(PORT_DMA, 1, 62, 32'hDEAD, lat, nw, nr);
      chk("t2_dma_lat", 32'(lat), 2);
      chk("t2_one_write", 32'(nw), 1);
      chk("t2_mem62", mem[62], 32'hDEAD);
      do_req(PORT_CPU, 0, 62, 0, lat, nw, nr);
      chk("t2_cpu_lat", 32'(lat), 2);
      chk("t2_one_read", 32'(nr), 1);
      chk("t2_readback", cpu_rdata, 32'hDEAD);
      // contention after reset: cpu first, strict alternation, ack every 2nd cycle
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("t3_rst_rdata", cpu_rdata | dma_rdata, 0);
      cpu_req = 1; cpu_we = 0; cpu_addr = 1;
      dma_req = 1; dma_we = 0; dma_addr = 2;
      nacks = 0;
      for (int c = 1; c <= 30 && nacks < 8; c++) begin
         @(negedge clk);
         if (cpu_ack && dma_ack) chk("t3_both_ack", 1, 0);
         if (cpu_ack || dma_ack) begin
            chk($sformatf("t3_port%0d", nacks), 32'(dma_ack), 32'(nacks % 2));
            chk($sformatf("t3_cyc%0d", nacks), 32'(c), 32'(2 * (nacks + 1)));
            chk($sformatf("t3_data%0d", nacks), dma_ack ? dma_rdata : cpu_rdata, dma_ack ? 106 : 105);
            nacks++;
         end
      end
      chk("t3_nacks", 32'(nacks), 8);
      cpu_req = 0; dma_req = 0;
      repeat (2) @(negedge clk);
      // out-of-range write
      do_req(PORT_CPU, 1, 64, 32'h1234, lat, nw, nr);
      chk("t4_lat", 32'(lat), 2);
      chk("t4_no_write", 32'(nw), 0);
      chk("t4_err", 32'(cpu_err), 1);
      chk("t4_rdata", cpu_rdata, 0);
      chk("t4_mem0", mem[0], 104);
      // reset during ACCESS of a dma write to address 3
      dma_req = 1; dma_we = 1; dma_addr = 3; dma_wdata = 32'hBEEF;
      @(negedge clk);
      chk("t5_in_access", 32'(dut.r_state), 32'(ACCESS));
      reset = 1; dma_req = 0;
      #1 chk("t5_write_gated", 32'(ram_MemWrite), 0);
      @(negedge clk);
      reset = 0;
      chk("t5_no_ack", 32'(dma_ack), 0);
      chk("t5_idle", 32'(dut.r_state), 32'(IDLE));
      chk("t5_mem3", mem[3], 107);
      @(negedge clk);
      chk("t5_no_late_ack", 32'(dma_ack), 0);
      // held cpu request: stall until ack, not re-eligible in DONE
      cpu_req = 1; cpu_we = 0; cpu_addr = 7;
      @(negedge clk);
      chk("t6_stall_access", 32'(cpu_stall), 1);
      @(negedge clk);
      chk("t6_ack", 32'(cpu_ack), 1);
      chk("t6_stall_low", 32'(cpu_stall), 0);
      chk("t6_rdata", cpu_rdata, 111);
      @(negedge clk);
      chk("t6_done_skip", 32'(dut.r_state), 32'(IDLE));
      chk("t6_no_read", 32'(ram_MemRead), 0);
      chk("t6_stall_again", 32'(cpu_stall), 1);
      @(negedge clk);
      chk("t6_second_read", 32'(ram_MemRead), 1);
      @(negedge clk);
      chk("t6_second_ack", 32'(cpu_ack), 1);
      cpu_req = 0;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
